ahb_sram_if: RTL and testbench
==============================

# ahb_sram_if

AHB-Lite slave front end that converts AHB transfers into the chip-select, write-enable, address and data controls of the two-bank, byte-lane SRAM core, and returns read data from its eight byte outputs. The block sits between the AHB interconnect and the SRAM core. Both blocks run on hclk. Reads complete with zero wait states. Writes are issued in the AHB data phase. A read that collides with a pending write is stalled for one cycle. Unsupported transfers get a two-cycle ERROR response.

## Interface
- SRAM_AW, 13, SRAM word-address width; the word address is haddr[SRAM_AW+1:2], and the bank select is haddr[SRAM_AW+2].
- hclk  in  1  sole clock; the SRAM core is clocked by the same net.
- hresetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  byte address; bits [31:16] are ignored (aliased).
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; values of 3 or more are illegal.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-wide ready.
- hready_resp  out  1  slave ready.
- hresp  out  2  00 = OKAY, 01 = ERROR.
- hrdata  out  32  read data.
- bank0_cen, bank1_cen  out  4 each  active-low byte-lane chip enables; bit n enables lane n.
- sram_w_en  out  1  active-low write enable.
- sram_addr  out  SRAM_AW  word address.
- sram_data  out  32  write data.
- sram_q0..sram_q7  in  8 each  SRAM outputs; q0–q3 are bank 0 lanes 0–3, q4–q7 are bank 1 lanes 0–3; each is valid the cycle after a read is enabled.

## Operation
- Address phase valid (apv) = hsel & hready & htrans[1].
- Legal transfer:
  - hsize of 0 has no alignment constraint.
  - hsize of 1 requires haddr[0] = 0.
  - hsize of 2 requires haddr[1:0] = 0.
  - hsize of 3 or more is illegal.
- Byte mask:
  - byte: 1 << haddr[1:0].
  - half: 4'b0011 << (2·haddr[1]).
  - word: 4'b1111.
- States: IDLE, RD, WR, RDSTALL, ERR1, ERR2.
- The SRAM is free in IDLE, RD and ERR2. In those states:
  - A legal apv read drives, combinationally: sram_addr = haddr word address; all four cen bits of the selected bank = 0; the other bank = 4'hF; sram_w_en = 1. The next state is RD.
  - A legal apv write registers the address, bank and mask. The next state is WR.
  - An illegal apv starts no SRAM access. The next state is ERR1.
  - Otherwise the next state is IDLE.
- WR (write data phase):
  - Drives sram_addr = registered address.
  - Selected-bank cen = ~mask; the other bank = 4'hF.
  - sram_w_en = 0; sram_data = hwdata.
  - hready_resp = 1.
  - Next-state decode is the same as in the free states, except that a legal apv read latches its address and bank and goes to RDSTALL.
- RDSTALL:
  - Issues the latched read to the SRAM.
  - hready_resp = 0, hresp = OKAY; the bus inputs are not sampled.
  - The next state is RD unconditionally.
- RD:
  - hrdata = {q3,q2,q1,q0} or {q7,q6,q5,q4}, selected by the registered bank.
  - hready_resp = 1.
- ERR1: hready_resp = 0, hresp = ERROR; the next state is ERR2.
- ERR2: hready_resp = 1, hresp = ERROR; a new address phase is sampled as in IDLE.
- hrdata = 0 outside RD.
- hresp = OKAY outside ERR1 and ERR2.
- IDLE and BUSY transfers, and cycles with hsel = 0, receive OKAY with zero wait states.

## Timing
- Reset values:
  - state = IDLE, hready_resp = 1, hresp = 00, hrdata = 0.
  - bank0_cen = bank1_cen = 4'hF, sram_w_en = 1, sram_addr = 0, sram_data = 0.
  - All SRAM controls are forced inactive while hresetn is low.
- Read latency:
  - Address phase at cycle N: the SRAM is enabled in cycle N, and hrdata is valid with hready_resp = 1 in cycle N+1.
  - After a write, hrdata is valid in N+2, with one wait cycle at N+1.
- Write timing: address phase at cycle N; the SRAM write is clocked at the end of cycle N+1, which is zero-wait.
- Back-to-back transfers:
  - Consecutive writes are zero-wait.
  - A read followed by a write is zero-wait.
  - Only a write followed by a read inserts RDSTALL.
- A read of a word written in the immediately preceding transfer returns the new data, because the write completes before the replayed read.
- Reset mid-operation discards any pending write, latched read or error; no SRAM write occurs.
- While hready = 0 from another slave, nothing is sampled, and WR still completes its write.

## Structure
- Package ahb_sram_pkg holds:
  - the htrans, hsize and hresp encodings;
  - the state enum;
  - SRAM_AW.
- Sub-module ahb_sram_lane_dec is a combinational decoder: (hsize, haddr[1:0]) → {legal, mask[3:0]}.
- The FSM, address/data registers and read mux live in ahb_sram_if.

## Test plan
- Word write of 32'hDEADBEEF to 0x0000_0010, then a word read of 0x10:
  - the write drives bank0_cen = 4'h0, sram_w_en = 0 and sram_addr = 4;
  - the read stalls one cycle and then returns 32'hDEADBEEF.
- Byte write of 8'hA5 to 0x0000_8003, then a read:
  - bank1_cen = 4'b0111 and bank0_cen = 4'hF during the write;
  - the read returns 32'hA5xxxxxx in lane 3 only, with the other lanes unchanged.
- Four back-to-back NONSEQ reads at 0x0, 0x4, 0x8 and 0xC:
  - hready_resp stays 1 throughout;
  - data appears one cycle after each address phase.
- Error cases: a halfword at 0x1 or hsize = 3 produces:
  - no cen asserted;
  - two cycles of hresp = 01 with hready_resp of 0 then 1;
  - an OKAY read immediately afterwards.
- Reset pulse during the WR cycle of a write to 0x20:
  - no sram_w_en = 0 is observed;
  - all outputs take their reset values;
  - a later read of 0x20 returns the old data.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared encodings, state type and SRAM geometry for the AHB-to-SRAM front end.
package ahb_sram_pkg;

  localparam int unsigned SRAM_AW = 13;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRdStall,
    StErr1,
    StErr2
  } state_e;

endpackage

// File: rtl/ahb_sram_bus_if.sv
// AHB-Lite slave signals plus the two-bank byte-lane SRAM control/data bundle.
interface ahb_sram_bus_if;
  import ahb_sram_pkg::*;

  logic               hsel;
  logic [31:0]        haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [31:0]        hwdata;
  logic               hready;
  logic               hready_resp;
  logic [1:0]         hresp;
  logic [31:0]        hrdata;

  logic [3:0]         bank0_cen;
  logic [3:0]         bank1_cen;
  logic               sram_w_en;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_data;
  logic [7:0]         sram_q0, sram_q1, sram_q2, sram_q3;
  logic [7:0]         sram_q4, sram_q5, sram_q6, sram_q7;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  sram_q0, sram_q1, sram_q2, sram_q3, sram_q4, sram_q5, sram_q6, sram_q7,
    output hready_resp, hresp, hrdata,
    output bank0_cen, bank1_cen, sram_w_en, sram_addr, sram_data
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output sram_q0, sram_q1, sram_q2, sram_q3, sram_q4, sram_q5, sram_q6, sram_q7,
    input  hready_resp, hresp, hrdata,
    input  bank0_cen, bank1_cen, sram_w_en, sram_addr, sram_data
  );

endinterface

// File: rtl/ahb_sram_lane_dec.sv
// Decodes transfer size and low address bits into legality and a byte-lane mask.
module ahb_sram_lane_dec
  import ahb_sram_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o,
  output logic [3:0] mask_o
);

  always_comb begin
    legal_o = 1'b0;
    mask_o  = 4'h0;
    case (hsize_i)
      HSIZE_BYTE: begin
        legal_o = 1'b1;
        mask_o  = 4'b0001 << addr_lo_i;
      end
      HSIZE_HALF: begin
        legal_o = ~addr_lo_i[0];
        mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        legal_o = (addr_lo_i == 2'b00);
        mask_o  = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave front end: zero-wait reads, data-phase writes, one-cycle stall on
// write-then-read, two-cycle ERROR for illegal size/alignment.
module ahb_sram_if
  import ahb_sram_pkg::*;
(
  input logic           hclk,
  input logic           hresetn,
  ahb_sram_bus_if.slave bus
);

  state_e             state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               bank_q, bank_d;
  logic [3:0]         mask_q, mask_d;

  logic               apv, legal, hbank;
  logic [3:0]         lane_mask;
  logic [SRAM_AW-1:0] haddr_word;

  logic               acc_bank, sram_w_en, hready_resp;
  logic [3:0]         acc_cen, bank0_cen, bank1_cen;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_data, hrdata;
  logic [1:0]         hresp;
  logic               sample;

  logic unused_bus;
  assign unused_bus = ^{bus.haddr[31:SRAM_AW+3], bus.htrans[0]};

  ahb_sram_lane_dec u_lane_dec (
    .hsize_i   (bus.hsize),
    .addr_lo_i (bus.haddr[1:0]),
    .legal_o   (legal),
    .mask_o    (lane_mask)
  );

  assign apv        = bus.hsel & bus.hready & bus.htrans[1];
  assign haddr_word = bus.haddr[SRAM_AW+1:2];
  assign hbank      = bus.haddr[SRAM_AW+2];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    bank_d      = bank_q;
    mask_d      = mask_q;
    acc_bank    = 1'b0;
    acc_cen     = 4'hF;
    sram_w_en   = 1'b1;
    sram_addr   = '0;
    sram_data   = 32'h0;
    hready_resp = 1'b1;
    hresp       = HRESP_OKAY;
    hrdata      = 32'h0;
    sample      = 1'b0;

    unique case (state_q)
      StIdle, StErr2: sample = 1'b1;
      StRd: begin
        sample = 1'b1;
        hrdata = bank_q ? {bus.sram_q7, bus.sram_q6, bus.sram_q5, bus.sram_q4}
                        : {bus.sram_q3, bus.sram_q2, bus.sram_q1, bus.sram_q0};
      end
      StWr: begin
        sample    = 1'b1;
        sram_addr = addr_q;
        acc_bank  = bank_q;
        acc_cen   = ~mask_q;
        sram_w_en = 1'b0;
        sram_data = bus.hwdata;
      end
      StRdStall: begin
        sram_addr   = addr_q;
        acc_bank    = bank_q;
        acc_cen     = 4'h0;
        hready_resp = 1'b0;
        state_d     = StRd;
      end
      StErr1: begin
        hready_resp = 1'b0;
        hresp       = HRESP_ERROR;
        state_d     = StErr2;
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StErr2) hresp = HRESP_ERROR;

    if (sample) begin
      state_d = StIdle;
      if (apv && !legal) begin
        state_d = StErr1;
      end else if (apv && bus.hwrite) begin
        addr_d  = haddr_word;
        bank_d  = hbank;
        mask_d  = lane_mask;
        state_d = StWr;
      end else if (apv) begin
        addr_d = haddr_word;
        bank_d = hbank;
        // The SRAM port is busy with the write, so replay the read next cycle.
        if (state_q == StWr) begin
          state_d = StRdStall;
        end else begin
          state_d   = StRd;
          sram_addr = haddr_word;
          acc_bank  = hbank;
          acc_cen   = 4'h0;
        end
      end
    end

    bank0_cen = acc_bank ? 4'hF : acc_cen;
    bank1_cen = acc_bank ? acc_cen : 4'hF;

    if (!hresetn) begin
      bank0_cen = 4'hF;
      bank1_cen = 4'hF;
      sram_w_en = 1'b1;
      sram_addr = '0;
      sram_data = 32'h0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      mask_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.bank0_cen   = bank0_cen;
  assign bus.bank1_cen   = bank1_cen;
  assign bus.sram_w_en   = sram_w_en;
  assign bus.sram_addr   = sram_addr;
  assign bus.sram_data   = sram_data;
  assign bus.hready_resp = hready_resp;
  assign bus.hresp       = hresp;
  assign bus.hrdata      = hrdata;

endmodule

// File: tb/tb_ahb_sram_if.sv
// Bench for ahb_sram_if: pipelined AHB driver, behavioural two-bank SRAM and a read scoreboard.
module tb_ahb_sram_if;
  import ahb_sram_pkg::*;

  localparam int unsigned Words = 1 << SRAM_AW;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_sram_bus_if bus ();

  ahb_sram_if dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  assign bus.hready = bus.hready_resp;

  // Behavioural SRAM: registered outputs, byte-lane enables, shared write enable.
  logic [31:0] mem0 [Words];
  logic [31:0] mem1 [Words];
  logic [31:0] q0_q, q1_q;

  always @(posedge hclk) begin
    for (int l = 0; l < 4; l++) begin
      if (!bus.bank0_cen[l]) begin
        if (!bus.sram_w_en) mem0[bus.sram_addr][8*l +: 8] <= bus.sram_data[8*l +: 8];
        else                q0_q[8*l +: 8] <= mem0[bus.sram_addr][8*l +: 8];
      end
      if (!bus.bank1_cen[l]) begin
        if (!bus.sram_w_en) mem1[bus.sram_addr][8*l +: 8] <= bus.sram_data[8*l +: 8];
        else                q1_q[8*l +: 8] <= mem1[bus.sram_addr][8*l +: 8];
      end
    end
  end

  assign bus.sram_q0 = q0_q[7:0];
  assign bus.sram_q1 = q0_q[15:8];
  assign bus.sram_q2 = q0_q[23:16];
  assign bus.sram_q3 = q0_q[31:24];
  assign bus.sram_q4 = q1_q[7:0];
  assign bus.sram_q5 = q1_q[15:8];
  assign bus.sram_q6 = q1_q[23:16];
  assign bus.sram_q7 = q1_q[31:24];

  typedef enum logic [1:0] {DpNone, DpRead, DpWrite, DpErr} dp_e;

  dp_e         dp_kind;
  logic [31:0] dp_addr, dp_wdata;
  logic [2:0]  dp_size;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [int];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0, stall_cnt = 0, errlo_cnt = 0, errhi_cnt = 0, cen_cnt = 0;
  logic [3:0]         we_cen0, we_cen1;
  logic [SRAM_AW-1:0] we_addr;
  logic [31:0]        we_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_mask(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    return 4'b0001 << lo;
      3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int key = int'(a[15:2]);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w = ref_rd(a);
    logic [3:0]  m = ref_mask(size, a[1:0]);
    for (int l = 0; l < 4; l++) if (m[l]) w[8*l +: 8] = d[8*l +: 8];
    ref_mem[int'(a[15:2])] = w;
  endtask

  task automatic monitor();
    if (!bus.sram_w_en) begin
      we_cnt++;
      we_cen0 = bus.bank0_cen;
      we_cen1 = bus.bank1_cen;
      we_addr = bus.sram_addr;
      we_data = bus.sram_data;
    end
    if (!bus.hready_resp && bus.hresp == HRESP_OKAY) stall_cnt++;
    if (bus.hresp == HRESP_ERROR && !bus.hready_resp) errlo_cnt++;
    if (bus.hresp == HRESP_ERROR && bus.hready_resp) errhi_cnt++;
    if (bus.bank0_cen != 4'hF || bus.bank1_cen != 4'hF) cen_cnt++;
  endtask

  // One AHB address phase, held while the slave stalls; completes the previous data phase.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bit accepted = 0;
    for (int t = 0; t < 8 && !accepted; t++) begin
      bus.hsel   = sel;
      bus.htrans = trans;
      bus.hwrite = wr;
      bus.hsize  = size;
      bus.haddr  = addr;
      bus.hwdata = (dp_kind == DpWrite) ? dp_wdata : 32'h0;
      @(negedge hclk);
      monitor();
      if (bus.hready_resp) begin
        case (dp_kind)
          DpRead: begin
            if (exp_q.size() == 0) check_eq("rd_underflow", 32'h1, 32'h0);
            else check_eq("rd_data", bus.hrdata, exp_q.pop_front());
            check_eq("rd_resp", {30'h0, bus.hresp}, {30'h0, HRESP_OKAY});
          end
          DpWrite: ref_wr(dp_addr, dp_size, dp_wdata);
          DpErr:   check_eq("err2_resp", {30'h0, bus.hresp}, {30'h0, HRESP_ERROR});
          default: ;
        endcase
        dp_kind = DpNone;
        if (sel && trans[1]) begin
          dp_addr  = addr;
          dp_size  = size;
          dp_wdata = wdata;
          if (size >= 3'd3 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00))
            dp_kind = DpErr;
          else if (wr) dp_kind = DpWrite;
          else begin
            dp_kind = DpRead;
            exp_q.push_back(ref_rd(addr));
          end
        end
        accepted = 1;
      end
      @(posedge hclk);
      #1;
    end
    if (!accepted) check_eq("accept_timeout", 32'h1, 32'h0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] size, input logic [31:0] a, input logic [31:0] d);
    bus_cycle(1'b1, HTRANS_NONSEQ, 1'b1, size, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    bus_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a, 32'h0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_cen0"}, {28'h0, bus.bank0_cen}, 32'hF);
    check_eq({tag, "_cen1"}, {28'h0, bus.bank1_cen}, 32'hF);
    check_eq({tag, "_wen"}, {31'h0, bus.sram_w_en}, 32'h1);
    check_eq({tag, "_addr"}, 32'(bus.sram_addr), 32'h0);
    check_eq({tag, "_data"}, bus.sram_data, 32'h0);
    check_eq({tag, "_ready"}, {31'h0, bus.hready_resp}, 32'h1);
    check_eq({tag, "_resp"}, {30'h0, bus.hresp}, 32'h0);
    check_eq({tag, "_rdata"}, bus.hrdata, 32'h0);
  endtask

  logic [31:0] pre_addrs [6];
  int s0, w0, e0, h0, c0;

  initial begin
    pre_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h20, 32'h8000};
    dp_kind = DpNone;
    // Reset held while the bus presents an active read: SRAM controls must stay idle.
    hresetn    = 1'b0;
    bus.hsel   = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_WORD;
    bus.haddr  = 32'h10;
    bus.hwdata = 32'h0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check_reset_outs("reset");
    @(posedge hclk);
    #1;
    bus.hsel = 1'b0;
    hresetn  = 1'b1;
    idle();

    // Preload with back-to-back writes: zero-wait.
    s0 = stall_cnt;
    w0 = we_cnt;
    foreach (pre_addrs[i]) wr(HSIZE_WORD, pre_addrs[i], 32'hC0DE_0000 | {16'h0, pre_addrs[i][15:0]});
    idle();
    check_eq("wr_b2b_stall", 32'(stall_cnt - s0), 32'h0);
    check_eq("wr_b2b_count", 32'(we_cnt - w0), 32'd6);

    // Word write then immediate read: one stall, new data returned.
    s0 = stall_cnt;
    wr(HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    idle();
    idle();
    check_eq("w10_cen0", {28'h0, we_cen0}, 32'h0);
    check_eq("w10_cen1", {28'h0, we_cen1}, 32'hF);
    check_eq("w10_addr", 32'(we_addr), 32'h4);
    check_eq("w10_data", we_data, 32'hDEAD_BEEF);
    check_eq("w10_stall", 32'(stall_cnt - s0), 32'h1);

    // Byte write to bank 1 lane 3, then read the whole word.
    wr(HSIZE_BYTE, 32'h8003, 32'hA500_0000);
    rd(32'h8000);
    idle();
    idle();
    check_eq("b1_cen1", {28'h0, we_cen1}, 32'h7);
    check_eq("b1_cen0", {28'h0, we_cen0}, 32'hF);
    check_eq("b1_model", ref_rd(32'h8000), 32'hA5DE_8000);

    // Back-to-back reads followed by a read-then-write: no wait states.
    s0 = stall_cnt;
    rd(32'h0);
    rd(32'h4);
    rd(32'h8);
    rd(32'hC);
    wr(HSIZE_HALF, 32'h6, 32'h1234_0000);
    rd(32'h0);
    rd(32'h4);
    idle();
    idle();
    check_eq("rd_b2b_stall", 32'(stall_cnt - s0), 32'h1);

    // Misaligned halfword read, then a read accepted in ERR2.
    e0 = errlo_cnt; h0 = errhi_cnt; c0 = cen_cnt;
    bus_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h1, 32'h0);
    rd(32'h4);
    idle();
    idle();
    check_eq("errh_lo", 32'(errlo_cnt - e0), 32'h1);
    check_eq("errh_hi", 32'(errhi_cnt - h0), 32'h1);
    check_eq("errh_cen", 32'(cen_cnt - c0), 32'h1);

    // hsize = 3 write: no SRAM write, then a read.
    e0 = errlo_cnt; h0 = errhi_cnt; c0 = cen_cnt; w0 = we_cnt;
    wr(3'd3, 32'h0, 32'hFFFF_FFFF);
    rd(32'h8);
    idle();
    idle();
    check_eq("errs_lo", 32'(errlo_cnt - e0), 32'h1);
    check_eq("errs_hi", 32'(errhi_cnt - h0), 32'h1);
    check_eq("errs_cen", 32'(cen_cnt - c0), 32'h1);
    check_eq("errs_we", 32'(we_cnt - w0), 32'h0);

    // Reset during the WR data phase of 0x20: the write is dropped.
    w0 = we_cnt;
    wr(HSIZE_WORD, 32'h20, 32'hBAD0_BAD0);
    hresetn    = 1'b0;
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = 32'hBAD0_BAD0;
    @(negedge hclk);
    check_reset_outs("midrst");
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    dp_kind = DpNone;
    idle();
    rd(32'h20);
    idle();
    idle();
    check_eq("midrst_we", 32'(we_cnt - w0), 32'h0);
    check_eq("midrst_old", ref_rd(32'h20), 32'hC0DE_0020);
    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
